// File: rtl/csi2_crc_check_ctrl.sv
// csi2_crc_check_ctrl: parses the lane-merged CSI-2 byte stream (DI, WC, ECC,
// payload, CRC footer), sequences an external byte-wise CRC16 engine and
// reports pass/fail per long packet.
// Optional feature: define CSI2_CRC_ERR_CNT_EN to build the saturating CRC
// error counter on err_cnt; otherwise err_cnt is tied to zero.
module csi2_crc_check_ctrl #(
   parameter int unsigned ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   input  logic [7:0]           s_data,
   input  logic                 s_sop,
   output logic                 crc_clr,
   output logic                 crc_en,
   output logic [7:0]           crc_data,
   input  logic [15:0]          crc_in,
   output logic [7:0]           pkt_di,
   output logic [15:0]          pkt_wc,
   output logic                 pkt_done,
   output logic                 crc_ok,
   output logic                 crc_err,
   output logic [15:0]          rx_crc,
   output logic                 pkt_abort,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      HDR1,
      HDR2,
      HDR3,
      PAYLOAD,
      CRC0,
      CRC1
   } state_t;

   state_t      state;
   logic [15:0] byte_cnt;
   logic        crc_match;
   logic        crc_fail_take;

   assign crc_en        = s_valid & (state == PAYLOAD);
   assign crc_data      = s_data;
   // The engine result is final here: the last payload byte was at least two cycles ago.
   assign crc_match     = (crc_in == {s_data, rx_crc[7:0]});
   assign crc_fail_take = s_valid & ~s_sop & (state == CRC1) & ~crc_match;

   // Packet parser: header capture, payload counting, CRC footer compare and result pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         byte_cnt  <= '0;
         crc_clr   <= 1'b1;
         pkt_di    <= '0;
         pkt_wc    <= '0;
         pkt_done  <= 1'b0;
         crc_ok    <= 1'b0;
         crc_err   <= 1'b0;
         rx_crc    <= '0;
         pkt_abort <= 1'b0;
      end else begin
         crc_clr   <= 1'b0;
         pkt_done  <= 1'b0;
         pkt_abort <= 1'b0;
         if (s_valid) begin
            if (s_sop) begin
               // A start-of-packet always wins; outside IDLE it truncates the current packet.
               pkt_di    <= s_data;
               crc_clr   <= 1'b1;
               pkt_abort <= (state != IDLE);
               state     <= HDR1;
            end else begin
               case (state)
                  IDLE: begin
                     state <= IDLE;
                  end
                  HDR1: begin
                     pkt_wc[7:0] <= s_data;
                     state       <= HDR2;
                  end
                  HDR2: begin
                     pkt_wc[15:8] <= s_data;
                     state        <= HDR3;
                  end
                  HDR3: begin
                     byte_cnt <= pkt_wc;
                     if (pkt_di[5:0] <= 6'h0F) begin
                        state <= IDLE;
                     end else if (pkt_wc == 16'd0) begin
                        state <= CRC0;
                     end else begin
                        state <= PAYLOAD;
                     end
                  end
                  PAYLOAD: begin
                     byte_cnt <= byte_cnt - 16'd1;
                     if (byte_cnt == 16'd1) begin
                        state <= CRC0;
                     end
                  end
                  CRC0: begin
                     rx_crc[7:0] <= s_data;
                     state       <= CRC1;
                  end
                  CRC1: begin
                     rx_crc[15:8] <= s_data;
                     pkt_done     <= 1'b1;
                     crc_ok       <= crc_match;
                     crc_err      <= ~crc_match;
                     state        <= IDLE;
                  end
                  default: begin
                     state <= IDLE;
                  end
               endcase
            end
         end
      end
   end

`ifdef CSI2_CRC_ERR_CNT_EN
   // Saturating count of failed CRC checks, updated together with pkt_done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (crc_fail_take && (err_cnt != '1)) begin
         err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_csi2_crc_check_ctrl.sv
// Scoreboard bench for csi2_crc_check_ctrl with a behavioural CRC16 engine.
module tb_csi2_crc_check_ctrl;

   localparam int unsigned W = 2;

   typedef logic [7:0] bytes_t[$];

   typedef struct {
      bit          abort;
      logic [7:0]  di;
      logic [15:0] wc;
      bit          ok;
      logic [15:0] rx;
      int          nen;
      logic [W-1:0] ec;
      int          cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic [7:0]    s_data;
   logic          s_sop;
   logic          crc_clr;
   logic          crc_en;
   logic [7:0]    crc_data;
   logic [15:0]   crc_in;
   logic [7:0]    pkt_di;
   logic [15:0]   pkt_wc;
   logic          pkt_done;
   logic          crc_ok;
   logic          crc_err;
   logic [15:0]   rx_crc;
   logic          pkt_abort;
   logic [W-1:0]  err_cnt;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            en_cnt = 0;
   logic          clr_model;
   logic [W-1:0]  exp_ec;
   logic [15:0]   eng;
   exp_t          q[$];

   always #5 clk = ~clk;

   csi2_crc_check_ctrl #(.ERR_CNT_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_sop     (s_sop),
      .crc_clr   (crc_clr),
      .crc_en    (crc_en),
      .crc_data  (crc_data),
      .crc_in    (crc_in),
      .pkt_di    (pkt_di),
      .pkt_wc    (pkt_wc),
      .pkt_done  (pkt_done),
      .crc_ok    (crc_ok),
      .crc_err   (crc_err),
      .rx_crc    (rx_crc),
      .pkt_abort (pkt_abort),
      .err_cnt   (err_cnt)
   );

   // Reflected CCITT polynomial, seed applied via crc_clr, LSB first.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      end
      return r;
   endfunction

   // Behavioural CRC engine attached to the sequencer.
   always @(posedge clk) begin
      if (crc_clr) eng <= 16'hFFFF;
      else if (crc_en) eng <= crc_step(eng, crc_data);
   end
   assign crc_in = eng;

   always @(posedge clk) cyc <= cyc + 1;

   // crc_clr must follow exactly one cycle behind each accepted start-of-packet.
   always @(posedge clk or posedge rst) begin
      if (rst) clr_model <= 1'b1;
      else clr_model <= s_valid && s_sop;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every pkt_done / pkt_abort.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         en_cnt = 0;
      end else begin
         chk("crc_clr", 32'(crc_clr), 32'(clr_model));
         if (crc_clr) chk("crc_en_while_clr", 32'(crc_en), 32'd0);
         if (pkt_done || pkt_abort) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got done=%0d abort=%0d expected none", pkt_done, pkt_abort);
            end else begin
               e = q.pop_front();
               chk("event_kind_abort", 32'(pkt_abort), 32'(e.abort));
               chk("event_kind_done", 32'(pkt_done), 32'(!e.abort));
               chk("event_cycle", 32'(cyc), 32'(e.cyc));
               if (!e.abort) begin
                  chk("pkt_di", 32'(pkt_di), 32'(e.di));
                  chk("pkt_wc", 32'(pkt_wc), 32'(e.wc));
                  chk("crc_ok", 32'(crc_ok), 32'(e.ok));
                  chk("crc_err", 32'(crc_err), 32'(!e.ok));
                  chk("rx_crc", 32'(rx_crc), 32'(e.rx));
                  chk("crc_en_count", 32'(en_cnt), 32'(e.nen));
                  chk("err_cnt", 32'(err_cnt), 32'(e.ec));
               end
               en_cnt = 0;
            end
         end
         if (crc_en) en_cnt++;
      end
   end

   task automatic drive(input logic [7:0] d, input bit sop, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            s_valid = 1'b0;
            s_sop   = 1'b0;
            s_data  = 8'($urandom);
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_sop   = sop;
      s_data  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         s_valid = 1'b0;
         s_sop   = 1'b0;
      end
   endtask

   // trunc >= 0 stops after that many payload bytes (no footer, no result expected).
   task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input bytes_t pl,
                           input logic [7:0] c0, input logic [7:0] c1, input bit exp_ok,
                           input bit gaps, input bit aborts, input int trunc);
      exp_t e;
      int   n;
      drive(di, 1'b1, gaps);
      if (aborts) begin
         e = '{default: 0};
         e.abort = 1'b1;
         e.cyc   = cyc + 1;
         q.push_back(e);
      end
      drive(wc[7:0], 1'b0, gaps);
      drive(wc[15:8], 1'b0, gaps);
      drive(8'h00, 1'b0, gaps);
      if (di[5:0] <= 6'h0F) return;
      n = (trunc >= 0) ? trunc : pl.size();
      for (int i = 0; i < n; i++) drive(pl[i], 1'b0, gaps);
      if (trunc >= 0) return;
      drive(c0, 1'b0, gaps);
      drive(c1, 1'b0, gaps);
`ifdef CSI2_CRC_ERR_CNT_EN
      if (!exp_ok && (exp_ec != '1)) exp_ec = exp_ec + 1'b1;
`endif
      e = '{default: 0};
      e.abort = 1'b0;
      e.di    = di;
      e.wc    = wc;
      e.ok    = exp_ok;
      e.rx    = {c1, c0};
      e.nen   = int'(wc);
      e.ec    = exp_ec;
      e.cyc   = cyc + 1;
      q.push_back(e);
   endtask

   task automatic reset_mid_packet(input bytes_t pl);
      send_pkt(8'h2A, 16'h0018, pl, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 5);
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_sop   = 1'b0;
      rst     = 1'b1;
      exp_ec  = '0;
      #1;
      chk("rst_mid_crc_clr", 32'(crc_clr), 32'd1);
      chk("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_mid_pkt_wc", 32'(pkt_wc), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      bytes_t good;
      bytes_t bad;
      bytes_t none;
      good = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
               8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
      bad = good;
      bad[5] = 8'hDD;
      none = {};
      rst = 1'b1;
      s_valid = 1'b0;
      s_sop = 1'b0;
      s_data = 8'h00;
      exp_ec = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_crc_clr", 32'(crc_clr), 32'd1);
      chk("reset_pkt_done", 32'(pkt_done), 32'd0);
      chk("reset_crc_ok", 32'(crc_ok), 32'd0);
      chk("reset_crc_err", 32'(crc_err), 32'd0);
      chk("reset_pkt_di", 32'(pkt_di), 32'd0);
      chk("reset_pkt_wc", 32'(pkt_wc), 32'd0);
      chk("reset_rx_crc", 32'(rx_crc), 32'd0);
      chk("reset_pkt_abort", 32'(pkt_abort), 32'd0);
      chk("reset_err_cnt", 32'(err_cnt), 32'd0);
      chk("reset_crc_en", 32'(crc_en), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      // Good packet, then the same packet with one corrupted payload byte.
      send_pkt(8'h2A, 16'h0018, good, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, -1);
      idle(2);
      send_pkt(8'h2A, 16'h0018, bad, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, -1);
      idle(2);
      // Zero-length long packet: footer equals the seed.
      send_pkt(8'h2A, 16'h0000, none, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, -1);
      idle(1);
      // Short packet immediately followed by a long one.
      send_pkt(8'h00, 16'h0001, none, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, -1);
      send_pkt(8'h2A, 16'h0018, good, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, -1);
      // Back-to-back: next s_sop lands in the pkt_done cycle.
      send_pkt(8'h2A, 16'h0018, good, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, -1);
      idle(2);
      // Truncation by a new s_sop, then a good packet with random gaps.
      send_pkt(8'h2A, 16'h0018, good, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 10);
      send_pkt(8'h2A, 16'h0018, good, 8'hF0, 8'h00, 1'b1, 1'b1, 1'b1, -1);
      idle(2);
      reset_mid_packet(good);
      idle(2);
      // Five failures: counter saturates at 3 when built with the counter.
      for (int k = 0; k < 5; k++) begin
         send_pkt(8'h2A, 16'h0018, bad, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, -1);
         idle(1);
      end
      idle(2);
      reset_mid_packet(good);
      idle(20);
      while (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: got none expected abort=%0d at cycle %0d", e.abort, e.cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
